display_port_driver: RTL and testbench

- Character source for the Apple 1 video terminal's display port; the sending end of the rd[7:1] / da / rda handshake that the terminal receives.
- Accepts 7-bit ASCII characters from an on-chip producer (host UART bridge or test sequencer) into a small FIFO.
- Presents each character to the terminal on rd[7:1], raises da, and completes the handshake against the terminal's rda.
- Sits in place of the PIA port B / CB2 side when the terminal is driven from the FPGA or a bench.

---
 rtl/terminal_pkg.sv | 14 +
 rtl/display_port_driver_if.sv | 16 +
 rtl/char_fifo.sv | 39 +++
 rtl/display_port_driver.sv | 97 +++++++++
 tb/tb_display_port_driver.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/terminal_pkg.sv
// terminal_pkg: shared constants and FSM state encoding for the Apple 1 display port
package terminal_pkg;
  localparam int ASCII_W = 7;
  localparam logic [ASCII_W-1:0] CR = 7'h0D;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_SETUP_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t LOAD = 3'd1;
  localparam state_t SETUP = 3'd2;
  localparam state_t WAIT_ACK = 3'd3;
  localparam state_t WAIT_RDY = 3'd4;
endpackage

// File: rtl/display_port_driver_if.sv
// display_port_driver_if: producer write port and terminal rd/da/rda handshake bundle
interface display_port_driver_if #(
  parameter int FIFO_DEPTH = terminal_pkg::DEF_FIFO_DEPTH
);
  logic                              wr_en;
  logic [terminal_pkg::ASCII_W-1:0]  wr_data;
  logic                              full;
  logic [$clog2(FIFO_DEPTH):0]       count;
  logic [7:1]                        rd;
  logic                              da;
  logic                              rda;
  logic                              busy;
  logic                              timeout;
  modport master (input wr_en, wr_data, rda, output full, count, rd, da, busy, timeout);
  modport slave (output wr_en, wr_data, rda, input full, count, rd, da, busy, timeout);
endinterface

// File: rtl/char_fifo.sv
// char_fifo: single-clock first-word-fall-through FIFO with full flag and occupancy count
module char_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic push, pop;
  assign full_o = count_q == CW'(DEPTH);
  assign push = wr_en_i && !full_o;
  assign pop = rd_en_i && count_q != '0;
  assign count_o = count_q;
  assign rd_data_o = mem_q[rptr_q];
  // power-of-two depth lets the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= wr_data_i;
endmodule

// File: rtl/display_port_driver.sv
// display_port_driver: buffers ASCII characters and sends them to the Apple 1 terminal
// over the rd[7:1]/da/rda handshake, with data setup time and a per-phase timeout.
module display_port_driver import terminal_pkg::*; #(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic clk,
  input logic rst_n,
  display_port_driver_if.master bus
);
  localparam int SW = SETUP_CYCLES > 1 ? $clog2(SETUP_CYCLES) : 1;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_t state_q, state_d;
  logic [ASCII_W-1:0] rd_q, rd_d, head;
  logic da_q, da_d, tmo_pulse_q, tmo_pulse_d;
  logic [SW-1:0] set_q, set_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic rda_m_q, rda_s_q, tmo_hit, fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  char_fifo #(.WIDTH(ASCII_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en_i(bus.wr_en),
    .wr_data_i(bus.wr_data),
    .rd_en_i(state_q == LOAD),
    .rd_data_o(head),
    .full_o(fifo_full),
    .count_o(fifo_count)
  );
  assign tmo_hit = TIMEOUT_CYCLES != 0 && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    rd_d = rd_q;
    da_d = da_q;
    set_d = set_q;
    tmo_pulse_d = 1'b0;
    tmo_d = (state_q == WAIT_ACK || state_q == WAIT_RDY) ? tmo_q + 1'b1 : '0;
    case (state_q)
      IDLE: if (fifo_count != '0 && rda_s_q) state_d = LOAD;
      LOAD: begin
        rd_d = head;
        set_d = SW'(SETUP_CYCLES - 1);
        state_d = SETUP;
      end
      SETUP: if (set_q == '0) begin
        da_d = 1'b1;
        state_d = WAIT_ACK;
      end else set_d = set_q - 1'b1;
      WAIT_ACK: if (!rda_s_q) begin
        da_d = 1'b0;
        state_d = WAIT_RDY;
      end else if (tmo_hit) begin
        da_d = 1'b0;
        tmo_pulse_d = 1'b1;
        state_d = IDLE;
      end
      WAIT_RDY: if (rda_s_q) state_d = IDLE;
      else if (tmo_hit) begin
        tmo_pulse_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        da_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) tmo_d = '0;
  end
  // rda is asynchronous to clk; the FSM only ever looks at rda_s_q
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rda_m_q <= 1'b0;
      rda_s_q <= 1'b0;
      state_q <= IDLE;
      rd_q <= '0;
      da_q <= 1'b0;
      tmo_pulse_q <= 1'b0;
      set_q <= '0;
      tmo_q <= '0;
    end else begin
      rda_m_q <= bus.rda;
      rda_s_q <= rda_m_q;
      state_q <= state_d;
      rd_q <= rd_d;
      da_q <= da_d;
      tmo_pulse_q <= tmo_pulse_d;
      set_q <= set_d;
      tmo_q <= tmo_d;
    end
  assign bus.rd = rd_q;
  assign bus.da = da_q;
  assign bus.busy = state_q != IDLE;
  assign bus.timeout = tmo_pulse_q;
  assign bus.full = fifo_full;
  assign bus.count = fifo_count;
endmodule

// File: tb/tb_display_port_driver.sv
// tb_display_port_driver: directed checks of FIFO, handshake timing, timeout and reset
module tb_display_port_driver;
  import terminal_pkg::*;
  localparam int SETUP_N = 4;
  localparam int TMO_N = 50;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  display_port_driver_if #(.FIFO_DEPTH(DEPTH)) bus ();
  display_port_driver #(.FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP_N), .TIMEOUT_CYCLES(TMO_N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic put(input logic [6:0] c);
    bus.wr_en = 1'b1;
    bus.wr_data = c;
    tick();
    bus.wr_en = 1'b0;
  endtask
  // counts how long rd has held the expected character before da rises
  task automatic wait_da(input logic [6:0] c, input string tag);
    int stable = 0;
    for (int i = 0; i < 200 && !bus.da; i++) begin
      stable = (bus.rd == c) ? stable + 1 : 0;
      tick();
    end
    chk({tag, "_da_rise"}, bus.da, 1);
    chk({tag, "_rd"}, bus.rd, c);
    chk({tag, "_setup"}, stable, SETUP_N);
  endtask
  task automatic xfer(input logic [6:0] c, input string tag);
    wait_da(c, tag);
    repeat (3) tick();
    bus.rda = 1'b0;
    tick();
    tick();
    chk({tag, "_da_hold"}, bus.da, 1);
    tick();
    chk({tag, "_da_fall"}, bus.da, 0);
    bus.rda = 1'b1;
    tick();
    tick();
    chk({tag, "_busy_rdy"}, bus.busy, 1);
    tick();
    chk({tag, "_busy_done"}, bus.busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic seen;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.rda = 1'b1;
    repeat (2) tick();
    bus.wr_en = 1'b1;
    bus.wr_data = 7'h55;
    tick();
    tick();
    bus.wr_en = 1'b0;
    tick();
    chk("rst_da", bus.da, 0);
    chk("rst_rd", bus.rd, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout", bus.timeout, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (bus.da || bus.busy) seen = 1'b1;
    end
    chk("idle_quiet", seen, 0);
    chk("idle_count", bus.count, 0);
    put(7'h41);
    chk("single_count", bus.count, 1);
    xfer(7'h41, "single");
    chk("single_empty", bus.count, 0);
    bus.rda = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 17; i++) begin
      put(7'h30 + i[6:0]);
      if (i == 14) chk("burst_not_full15", bus.full, 0);
      if (i == 15) begin
        chk("burst_full16", bus.full, 1);
        chk("burst_cnt16", bus.count, 16);
      end
    end
    chk("burst_drop_cnt", bus.count, 16);
    chk("burst_drop_full", bus.full, 1);
    bus.rda = 1'b1;
    for (int i = 0; i < 16; i++) xfer(7'h30 + i[6:0], "burst");
    chk("burst_empty", bus.count, 0);
    chk("burst_not_full", bus.full, 0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (bus.da) seen = 1'b1;
    end
    chk("burst_no_extra", seen, 0);
    bus.rda = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) put(7'h50 + i[6:0]);
    chk("sim_cnt5", bus.count, 5);
    bus.rda = 1'b1;
    tick();
    tick();
    chk("sim_idle", bus.busy, 0);
    tick();
    chk("sim_load", bus.busy, 1);
    chk("sim_cnt_load", bus.count, 5);
    put(7'h55);
    chk("sim_cnt_same", bus.count, 5);
    for (int i = 0; i < 6; i++) xfer(7'h50 + i[6:0], "sim");
    chk("sim_empty", bus.count, 0);
    put(7'h61);
    wait_da(7'h61, "tmo");
    seen = 1'b0;
    repeat (TMO_N - 1) begin
      tick();
      if (bus.timeout || !bus.da) seen = 1'b1;
    end
    chk("tmo_early", seen, 0);
    tick();
    chk("tmo_pulse", bus.timeout, 1);
    chk("tmo_da", bus.da, 0);
    chk("tmo_busy", bus.busy, 0);
    tick();
    chk("tmo_single", bus.timeout, 0);
    bus.rda = 1'b0;
    repeat (4) tick();
    bus.rda = 1'b1;
    repeat (4) tick();
    chk("tmo_no_retry", bus.busy, 0);
    put(CR);
    xfer(CR, "next");
    chk("next_empty", bus.count, 0);
    put(7'h71);
    put(7'h72);
    put(7'h73);
    wait_da(7'h71, "mid");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_da_async", bus.da, 0);
    chk("mid_count", bus.count, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_rd", bus.rd, 0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (bus.da || bus.busy) seen = 1'b1;
    end
    chk("mid_no_stale", seen, 0);
    chk("mid_count_after", bus.count, 0);
    chk("mid_rd_after", bus.rd, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
